// File: rtl/mux_nt1_pipe_if.sv
// mux_nt1_pipe_if: handshake and bus bundle for mux_nt1_pipe.
//   slave  modport : the selector block (consumes in_*, out_ready, cnt_clr)
//   master modport : the surrounding logic / testbench
// Signals:
//   in_data[NUM_IN*WIDTH], in_sel[SEL_W], in_valid, in_ready  - upstream side
//   out_data[WIDTH], out_err, out_valid, out_ready             - downstream side
//   cnt_clr, sel_err_cnt[8]                                    - error counter
//   out_par (only with MUX_NT1_PIPE_PARITY_EN)                 - stored parity
interface mux_nt1_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;
    logic                    cnt_clr;
    logic [7:0]              sel_err_cnt;
`ifdef MUX_NT1_PIPE_PARITY_EN
    logic                    out_par;
`endif

    modport slave (
        input  in_data, in_sel, in_valid, out_ready, cnt_clr,
`ifdef MUX_NT1_PIPE_PARITY_EN
        output out_par,
`endif
        output in_ready, out_data, out_err, out_valid, sel_err_cnt
    );

    modport master (
        output in_data, in_sel, in_valid, out_ready, cnt_clr,
`ifdef MUX_NT1_PIPE_PARITY_EN
        input  out_par,
`endif
        input  in_ready, out_data, out_err, out_valid, sel_err_cnt
    );
endinterface

// File: rtl/mux_nt1_pipe.sv
// mux_nt1_pipe: N-to-1 WIDTH-bit registered selector feeding a 2-entry FIFO
// skid buffer, with out-of-range select detection and a saturating error count.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; discards buffered entries
//   bus    - mux_nt1_pipe_if.slave (in_*/out_* handshake, cnt_clr, sel_err_cnt)
// Optional feature: define MUX_NT1_PIPE_PARITY_EN to add bus.out_par, the
// XOR-reduce of the head entry's data, computed at push and stored per entry.
module mux_nt1_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
) (
    input logic           clk,
    input logic           rst_n,
    mux_nt1_pipe_if.slave bus
);
    // Entry 0 is always the head; entry 1 only holds data when count == 2.
    logic [1:0][WIDTH-1:0] data_q, data_d;
    logic [1:0]            err_q, err_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [7:0]            ecnt_q, ecnt_d;
`ifdef MUX_NT1_PIPE_PARITY_EN
    logic [1:0]            par_q, par_d;
`endif

    logic             push, pop, sel_err;
    logic [WIDTH-1:0] sel_data;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Channel select; out-of-range selects fall through to zero data.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k))
                sel_data = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    assign sel_err = (32'(bus.in_sel) >= NUM_IN);

    always_comb begin
        data_d = data_q;
        err_d  = err_q;
`ifdef MUX_NT1_PIPE_PARITY_EN
        par_d  = par_q;
`endif
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};

        if (pop) begin
            data_d[0] = data_q[1];
            err_d[0]  = err_q[1];
`ifdef MUX_NT1_PIPE_PARITY_EN
            par_d[0]  = par_q[1];
`endif
        end

        // Write slot is 1 only when one entry stays resident (count 1, no pop).
        if (push) begin
            if (cnt_q == 2'd1 && !pop) begin
                data_d[1] = sel_data;
                err_d[1]  = sel_err;
`ifdef MUX_NT1_PIPE_PARITY_EN
                par_d[1]  = ^sel_data;
`endif
            end else begin
                data_d[0] = sel_data;
                err_d[0]  = sel_err;
`ifdef MUX_NT1_PIPE_PARITY_EN
                par_d[0]  = ^sel_data;
`endif
            end
        end

        // Clear wins, but an error accepted in the clearing cycle still counts.
        ecnt_d = ecnt_q;
        if (bus.cnt_clr)
            ecnt_d = (push && sel_err) ? 8'd1 : 8'd0;
        else if (push && sel_err && ecnt_q != 8'hFF)
            ecnt_d = ecnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            err_q  <= '0;
            cnt_q  <= '0;
            ecnt_q <= '0;
`ifdef MUX_NT1_PIPE_PARITY_EN
            par_q  <= '0;
`endif
        end else begin
            data_q <= data_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            ecnt_q <= ecnt_d;
`ifdef MUX_NT1_PIPE_PARITY_EN
            par_q  <= par_d;
`endif
        end
    end

    // All outputs derive from registered state only.
    assign bus.in_ready    = (cnt_q != 2'd2);
    assign bus.out_valid   = (cnt_q != 2'd0);
    assign bus.out_data    = bus.out_valid ? data_q[0] : '0;
    assign bus.out_err     = bus.out_valid & err_q[0];
    assign bus.sel_err_cnt = ecnt_q;
`ifdef MUX_NT1_PIPE_PARITY_EN
    assign bus.out_par     = bus.out_valid & par_q[0];
`endif
endmodule
